// File: rtl/ps2_keybd_rx_pkg.sv
// PS/2 receiver shared definitions: FSM state encodings, frame constants, parity helper.
package ps2_keybd_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

  localparam int   DATA_BITS = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Odd parity holds when data bits plus parity bit contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [DATA_BITS-1:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_keybd_rx_fifo.sv
// Synchronous FIFO for received scan codes; dout shows the head combinationally (zero when empty).
// Push while full is dropped unless a pop lands in the same cycle; pop while empty is ignored.
module ps2_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [WIDTH-1:0] r_mem [2**AW];
  logic             w_wr;
  logic             w_rd;

  assign empty = (r_wptr == r_rptr);
  assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  // A simultaneous pop frees the slot the push needs, so full+push+pop keeps both.
  assign w_wr  = push && (!full || pop);
  assign w_rd  = pop && !empty;
  assign dout  = empty ? '0 : r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_rd) r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ps2_keybd_rx.sv
// PS/2 keyboard receiver: sync + falling-edge detect, 11-bit frame FSM, scan-code FIFO; rdy rises 4 clk after stop edge.
// Full FIFO drops new bytes. Define KEYBD_PARITY_CHECK_EN to discard frames with bad odd parity.
module ps2_keybd_rx
  import ps2_keybd_rx_pkg::*;
#(
  parameter int FIFO_AW     = 3,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       done,
  output logic       rdy,
  output logic [7:0] dout,
  input  logic       keybd_clk,
  input  logic       keybd_data
);

  localparam int TO_W  = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int CNT_W = $clog2(DATA_BITS);

  ps2_state_t         r_state;
  ps2_state_t         w_state_nxt;
  logic               r_clk_s1, r_clk_s2, r_clk_d;
  logic               r_dat_s1, r_dat_s2;
  logic [CNT_W-1:0]   r_cnt;
  logic [7:0]         r_sr;
  logic [TO_W-1:0]    r_to_cnt;
  logic               r_push;
  logic               w_fall;
  logic               w_dat;
  logic               w_to_hit;
  logic               w_good;
  logic               w_empty;
  logic               w_unused_full;
`ifdef KEYBD_PARITY_CHECK_EN
  logic               r_par;
`endif

  assign w_fall   = r_clk_d & ~r_clk_s2;
  assign w_dat    = r_dat_s2;
  assign w_to_hit = (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));
`ifdef KEYBD_PARITY_CHECK_EN
  assign w_good   = (w_dat == STOP_BIT) && odd_parity_ok(r_sr, r_par);
`else
  assign w_good   = (w_dat == STOP_BIT);
`endif

  // Idle PS/2 lines are high, so synchronizers come out of reset at 1 to avoid a false edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_clk_d  <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= keybd_clk;
      r_clk_s2 <= r_clk_s1;
      r_clk_d  <= r_clk_s2;
      r_dat_s1 <= keybd_data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_fall && w_dat == START_BIT) w_state_nxt = ST_DATA;
      ST_DATA:   if (w_fall && r_cnt == CNT_W'(DATA_BITS - 1)) w_state_nxt = ST_PARITY;
      ST_PARITY: if (w_fall) w_state_nxt = ST_STOP;
      ST_STOP:   if (w_fall) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
    if (r_state != ST_IDLE && !w_fall && w_to_hit) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_sr     <= '0;
      r_to_cnt <= '0;
      r_push   <= 1'b0;
`ifdef KEYBD_PARITY_CHECK_EN
      r_par    <= 1'b0;
`endif
    end else begin
      r_push <= 1'b0;
      if (w_fall || r_state == ST_IDLE) r_to_cnt <= '0;
      else if (!w_to_hit)               r_to_cnt <= r_to_cnt + TO_W'(1);
      if (w_fall) begin
        case (r_state)
          ST_IDLE: r_cnt <= '0;
          ST_DATA: begin
            r_sr  <= {w_dat, r_sr[7:1]};
            r_cnt <= r_cnt + CNT_W'(1);
          end
`ifdef KEYBD_PARITY_CHECK_EN
          ST_PARITY: r_par <= w_dat;
`endif
          ST_STOP: r_push <= w_good;
          default: ;
        endcase
      end
    end
  end

  ps2_fifo #(
    .WIDTH (8),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (r_push),
    .din   (r_sr),
    .pop   (done),
    .dout  (dout),
    .empty (w_empty),
    .full  (w_unused_full)
  );

  assign rdy = ~w_empty;

endmodule

// File: tb/tb_ps2_keybd_rx.sv
// Bench for ps2_keybd_rx: scaled PS/2 clock (20 clk half period) and short timeout keep runtime small.
module tb_ps2_keybd_rx;

  localparam int TO = 200;
  localparam int HP = 20;
`ifdef KEYBD_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       done;
  logic       rdy;
  logic [7:0] dout;
  logic       keybd_clk;
  logic       keybd_data;

  always #10 clk = ~clk;

  ps2_keybd_rx #(.FIFO_AW(3), .TIMEOUT_CYC(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .done       (done),
    .rdy        (rdy),
    .dout       (dout),
    .keybd_clk  (keybd_clk),
    .keybd_data (keybd_data)
  );

  typedef struct {
    logic [7:0] d;
    bit         par_flip;
    bit         stop;
    bit         exp_push;
    bit         drain;
  } vec_t;

  vec_t       vecs[5];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // bits[0]=first bit on the wire. Each bit: data set while clock high, then HP cycles low.
  task automatic send_bits(input logic [10:0] bits, input int nbits, input bit chk_lat, input bit pop_on_push);
    int lat = 0;
    for (int b = 0; b < nbits; b++) begin
      @(posedge clk); #1 keybd_data = bits[b];
      repeat (HP - 1) @(posedge clk);
      @(posedge clk); #1 keybd_clk = 1'b0;
      for (int c = 1; c <= HP; c++) begin
        @(posedge clk); #1;
        if (b == 10) begin
          if (chk_lat && lat == 0 && rdy) lat = c;
          if (pop_on_push && c == 3) begin
            check("head_at_pop_push", dout, exp_q.pop_front());
            done = 1'b1;
          end
          if (pop_on_push && c == 4) done = 1'b0;
        end
      end
      keybd_clk = 1'b1;
    end
    @(posedge clk); #1 keybd_data = 1'b1;
    repeat (2 * HP) @(posedge clk);
    #1;
    if (chk_lat) begin
      n_tests++;
      if (lat < 1 || lat > 4) begin
        n_fail++;
        $display("FAIL stop_to_rdy_latency: got %0d cycles (0 = never), expected 1..4", lat);
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit par_flip, input bit stop,
                            input bit exp_push, input bit chk_lat, input bit pop_on_push);
    logic par;
    par = ~(^d) ^ par_flip;
    send_bits({stop, par, d, 1'b0}, 11, chk_lat, pop_on_push);
    if (exp_push && exp_q.size() < 8) exp_q.push_back(d);
  endtask

  task automatic do_read(input string name);
    int w = 0;
    while (!rdy && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    check({name, "_rdy"}, rdy, 1);
    check({name, "_dout"}, dout, exp_q.pop_front());
    done = 1'b1;
    @(posedge clk); #1 done = 1'b0;
  endtask

  task automatic drain(input string name);
    while (exp_q.size() > 0) do_read(name);
    @(posedge clk); #1;
    check({name, "_empty_rdy"}, rdy, 0);
    check({name, "_empty_dout"}, dout, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b0;
    done       = 1'b0;
    keybd_clk  = 1'b1;
    keybd_data = 1'b1;
    vecs[0] = '{8'hF0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{8'h1C, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[2] = '{8'h1C, 1'b1, 1'b1, !PAR_EN, 1'b1};
    vecs[3] = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{8'h5A, 1'b0, 1'b1, 1'b1, 1'b1};

    repeat (5) @(posedge clk);
    #1;
    check("reset_rdy", rdy, 0);
    check("reset_dout", dout, 0);
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // Single frame with latency check, then one read empties the FIFO.
    send_frame(8'h1C, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    drain("single_1c");

    // Back-to-back, parity error, stop error, recovery.
    for (int i = 0; i < 5; i++) begin
      send_frame(vecs[i].d, vecs[i].par_flip, vecs[i].stop, vecs[i].exp_push, 1'b0, 1'b0);
      if (vecs[i].drain) drain($sformatf("vec%0d", i));
    end

    // Partial frame aborted by timeout, then a full frame must arrive intact.
    send_bits(11'b000_0001_1010, 5, 1'b0, 1'b0);
    repeat (TO + 50) @(posedge clk);
    #1;
    send_frame(8'h29, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    drain("timeout_29");

    // Partial frame cut by reset: queued byte lost, next frame intact.
    send_frame(8'h33, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    send_bits(11'b000_0001_1010, 5, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mid_frame_rdy", rdy, 0);
    check("rst_mid_frame_dout", dout, 0);
    exp_q.delete();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    send_frame(8'h29, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    drain("after_rst_29");

    // Overflow: ninth byte dropped.
    for (int k = 1; k <= 9; k++) send_frame(8'(k), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    drain("overflow");

    // Full FIFO with pop on the push cycle: both take effect.
    for (int k = 8'h11; k <= 8'h18; k++) send_frame(8'(k), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    send_frame(8'h19, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    drain("full_pop_push");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
